seq_detect_param: RTL

//  Parametrised serial bit-pattern detector, successor to the fixed 3-state detector.

---
 rtl/seq_detect_param.sv | 85 ++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with overlap/non-overlap mode and soft clear.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detect_param #(
  parameter int               PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             din,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FW       = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic               hit;

  generate
    if (PAT_LEN == 1) begin : g_shift1
      assign hist_shift = din;
    end else begin : g_shiftn
      assign hist_shift = {hist_q[PAT_LEN-2:0], din};
    end
  endgenerate

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    hit     = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d  = hist_shift;
      fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      hit     = (fill_d == FILL_MAX) && (hist_d == PATTERN);
      match_d = hit;
      // Non-overlap: a hit forces the next match to be built from fresh bits.
      if (hit && !OVERLAP) fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (hit && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = CNT_W'(0);
`endif

endmodule
